idct_2d_rowcol_ctrl: RTL and testbench
======================================

# idct_2d_rowcol_ctrl

Sequencer that computes an 8x8 2D inverse DCT by time-sharing one external combinational 1D IDCT core (IDCT_1D, 8x12-bit in, 8x11-bit out) for a row pass and then a column pass. It owns the 8x8 transpose buffer, the pass/index counters and the valid/ready handshakes on both sides. It sits between the dequantiser (input) and the level-shift/clamp stage (output) of the JPEG decode path.

## Interface

- `IN_W`, default 12: coefficient width per element, on input and on the core input.
- `OUT_W`, default 11: core output element width; also the transpose buffer and output element width.
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `in_valid`, input, 1: input row valid.
- `in_ready`, output, 1: block accepts an input row.
- `in_data`, input, 8*IN_W: one coefficient row. Element i is at [IN_W*(8-i)-1 : IN_W*(7-i)], so element 0 is the MSBs.
- `core_in`, output, 8*IN_W: drives the 1D core input. Same element order.
- `core_out`, input, 8*OUT_W: 1D core result. Element k is at [OUT_W*(8-k)-1 : OUT_W*(7-k)].
- `out_valid`, output, 1: output column valid.
- `out_ready`, input, 1: downstream accepts the column.
- `out_data`, output, 8*OUT_W: 2D result column `out_idx`. Element r is pixel row r.
- `out_idx`, output, 3: column index, 0..7.
- `out_last`, output, 1: high with column 7.
- `busy`, output, 1: high whenever the state is not ROW, or `row_cnt` is not 0.

## Operation

- Two states: ROW and COL. Reset state is ROW.
- **ROW state**
  - `in_ready`=1. `core_in` = `in_data`.
  - On each `in_valid && in_ready` edge, write buf[k][row_cnt] <= core_out element k, for k = 0..7. This stores the transpose. Then `row_cnt`++.
  - The handshake that accepts row 7 moves the state to COL, clears `row_cnt` and sets `col_cnt`=0.
- **COL state**
  - `in_ready`=0. `out_valid`=1.
  - `core_in` element r = sign-extension of buf[col_cnt][r] from OUT_W to IN_W bits.
  - `out_data` = `core_out` (combinational pass-through). `out_idx` = `col_cnt`. `out_last` = (`col_cnt`==7).
  - On each `out_valid && out_ready` edge, `col_cnt`++.
  - The handshake on column 7 returns the state to ROW with `col_cnt`=0.
- **Buffer**
  - 8x8xOUT_W flops, not reset.
  - Written only in ROW on an accepted beat; held unchanged in COL.
- **Arithmetic**
  - The block does no arithmetic. Scaling and truncation belong to the core.
  - Widening from 11 to 12 bits is sign extension only.
- **No overlap**
  - A new block is not accepted until the last column of the previous block has been taken.
  - There is no double buffering.

## Timing

- **Reset**
  - rst_n=0 at a rising edge gives, on the next cycle: state ROW, `row_cnt`=`col_cnt`=0, `in_ready`=1, `out_valid`=0, `out_last`=0, `out_idx`=0, `busy`=0.
  - `out_data` and `core_in` in COL are don't-care after reset. `core_in` in ROW equals `in_data`.
  - Reset mid-block discards the partial block. The next accepted row is row 0 of a new block.
- **Latency**
  - The 8th input handshake at edge N gives `out_valid`=1 with column 0 in the cycle after edge N.
  - With `out_ready` held at 1, columns 0..7 are presented in consecutive cycles.
  - `in_ready` returns to 1 in the cycle after the column-7 handshake.
- **Throughput**: at best 16 cycles per 8x8 block, 8 in and 8 out.
- **Backpressure**
  - While `out_valid && !out_ready`, `out_data`, `out_idx` and `out_last` hold stable.
  - They are stable because `core_in` depends only on the buffer and `col_cnt`.
- **Idle input**: `in_valid`=0 in ROW holds `row_cnt` and the buffer. Gaps between rows are allowed.
- **Combinational paths**
  - `in_data` to `core_in`, and `core_out` to `out_data`, are combinational.
  - The core sits in the same cycle as buffer writes and output, so the full 1D core delay must meet one clock period.
  - No input-to-output combinational path exists between `in_valid` and `out_ready`.

## Test plan

- **Zero block**: 8 all-zero rows, `out_ready`=1.
  - Expect 8 columns, all elements 0.
  - `out_idx` 0..7, `out_last` only on column 7, `in_ready` back to 1 one cycle later.
- **DC positive**: row 0 element 0 = 64, everything else 0.
  - Row pass gives 181*64>>9 = 22 in every buf[k][0].
  - Column pass gives 181*22>>9 = 7.
  - All 64 outputs = 7.
- **DC negative**: row 0 element 0 = -64.
  - Row values are -23 (floor).
  - Column pass gives floor(181*-23/512) = -9, so all 64 outputs = -9.
  - This checks the 11-to-12-bit sign extension.
- **Backpressure and gaps**
  - Feed rows with `in_valid` dropped every other cycle.
  - Hold `out_ready`=0 for 5 cycles at column 3.
  - Expect `out_data` and `out_idx`=3 stable and `in_ready`=0 throughout, with the results identical to the no-stall run.
- **Reset mid-block**
  - Accept 4 rows, assert rst_n=0 for 1 cycle.
  - Expect `in_ready`=1, `busy`=0 and `out_valid`=0.
  - A following DC-64 block yields all 7s.
- **Back-to-back blocks**
  - Send two blocks: DC 64, then DC -64, with `out_ready`=1.
  - Expect 64 outputs of 7, then 64 outputs of -9.
  - No input row may be accepted while in COL.

Source files
------------

// File: rtl/idct_2d_rowcol_ctrl.sv
// idct_2d_rowcol_ctrl
//
// Row/column sequencer for an 8x8 2D inverse DCT built around a single
// external combinational 1D IDCT core. Eight input rows go through the core
// one at a time. Each row result is written transposed into an 8x8 buffer.
// The eight buffer columns then go back through the same core and are
// presented downstream, one column per beat.
//
// Ports
//   clk        : sole clock, rising edge
//   rst_n      : synchronous active-low reset (control state only)
//   in_valid   : input row valid
//   in_ready   : block accepts an input row (high only in the row pass)
//   in_data    : one coefficient row, element 0 in the MSBs
//   core_in    : to 1D core; in_data in the row pass, a sign-extended
//                buffer column in the column pass
//   core_out   : from 1D core, element 0 in the MSBs
//   out_valid  : output column valid (high only in the column pass)
//   out_ready  : downstream accepts the column
//   out_data   : 2D result column out_idx (core_out pass-through)
//   out_idx    : column index 0..7
//   out_last   : high with column 7
//   busy       : a block is partially received or being emitted
module idct_2d_rowcol_ctrl #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*IN_W-1:0]   in_data,
  output logic [8*IN_W-1:0]   core_in,
  input  logic [8*OUT_W-1:0]  core_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*OUT_W-1:0]  out_data,
  output logic [2:0]          out_idx,
  output logic                out_last,
  output logic                busy
);

  typedef enum logic [0:0] {
    ST_ROW = 1'b0,
    ST_COL = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] row_cnt_q, row_cnt_d;
  logic [2:0] col_cnt_q, col_cnt_d;
  logic       in_ready_q;
  logic       out_valid_q;
  logic       out_last_q;
  logic       busy_q;
  logic       in_fire;
  logic       out_fire;

  // Transpose buffer: tbuf_q[k][r] holds element k of row-pass result r,
  // so tbuf_q[c] is directly column c of the intermediate matrix.
  logic signed [OUT_W-1:0] tbuf_q [8][8];

  // Widening into the core is pure sign extension; the core owns all
  // scaling and truncation.
  function automatic logic signed [IN_W-1:0] sext(input logic signed [OUT_W-1:0] v);
    return IN_W'(v);
  endfunction

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;

  // Next-state logic for the pass sequencer
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    case (state_q)
      ST_ROW: begin
        if (in_fire) begin
          if (row_cnt_q == 3'd7) begin
            state_d   = ST_COL;
            row_cnt_d = 3'd0;
            col_cnt_d = 3'd0;
          end else begin
            row_cnt_d = row_cnt_q + 3'd1;
          end
        end
      end
      ST_COL: begin
        if (out_fire) begin
          if (col_cnt_q == 3'd7) begin
            state_d   = ST_ROW;
            col_cnt_d = 3'd0;
          end else begin
            col_cnt_d = col_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = ST_ROW;
    endcase
  end

  // Control registers; handshake flags are registered from the next state
  // so neither ready nor valid has a path from any input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_ROW;
      row_cnt_q   <= 3'd0;
      col_cnt_q   <= 3'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      col_cnt_q   <= col_cnt_d;
      in_ready_q  <= (state_d == ST_ROW);
      out_valid_q <= (state_d == ST_COL);
      out_last_q  <= (state_d == ST_COL) && (col_cnt_d == 3'd7);
      busy_q      <= (state_d != ST_ROW) || (row_cnt_d != 3'd0);
    end
  end

  // Buffer write: data only, never reset. Only accepted row beats write it,
  // so it holds still for the whole column pass.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int k = 0; k < 8; k++) begin
        tbuf_q[k][row_cnt_q] <= core_out[OUT_W*(7-k) +: OUT_W];
      end
    end
  end

  // Core input mux: depends only on state, buffer and col_cnt in the column
  // pass, which keeps out_data stable under backpressure.
  always_comb begin
    core_in = in_data;
    if (state_q == ST_COL) begin
      for (int r = 0; r < 8; r++) begin
        core_in[IN_W*(7-r) +: IN_W] = sext(tbuf_q[col_cnt_q][r]);
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_idx   = col_cnt_q;
  assign out_data  = core_out;
  assign busy      = busy_q;

endmodule

// File: tb/tb_idct_2d_rowcol_ctrl.sv
module tb_idct_2d_rowcol_ctrl;
  localparam int IN_W  = 12;
  localparam int OUT_W = 11;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [8*IN_W-1:0]   in_data;
  logic [8*IN_W-1:0]   core_in;
  logic [8*OUT_W-1:0]  core_out;
  logic                out_valid;
  logic                out_ready;
  logic [8*OUT_W-1:0]  out_data;
  logic [2:0]          out_idx;
  logic                out_last;
  logic                busy;

  int n_chk  = 0;
  int n_fail = 0;

  int                 blk [8][8];   // blk[row][elem] coefficients
  logic [8*OUT_W-1:0] exp_col [8];  // expected output column c

  always #5 clk = ~clk;

  idct_2d_rowcol_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .core_in   (core_in),
    .core_out  (core_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  // ---------------- external 1D IDCT core model ----------------
  // y[k] = floor((181*x[0] + sum_{i>0} 256*cos((2k+1)i*pi/16)*x[i]) / 512),
  // truncated to OUT_W bits.
  function automatic int cosq(input int m);
    case (m)
      0: return 256; 1: return 251; 2: return 237; 3: return 213;
      4: return 181; 5: return 142; 6: return 98;  7: return 50;
      default: return 0;
    endcase
  endfunction

  function automatic int cw(input int i, input int k);
    int m;
    if (i == 0) return 181;
    m = ((2*k+1)*i) % 32;
    if (m <= 8)       return cosq(m);
    else if (m <= 16) return -cosq(16-m);
    else if (m <= 24) return -cosq(m-16);
    else              return cosq(32-m);
  endfunction

  function automatic logic [8*OUT_W-1:0] core_fn(input logic [8*IN_W-1:0] v);
    logic [8*OUT_W-1:0]      res;
    logic signed [IN_W-1:0]  e;
    int                      acc;
    int                      x;
    res = '0;
    for (int k = 0; k < 8; k++) begin
      acc = 0;
      for (int i = 0; i < 8; i++) begin
        e   = v[IN_W*(7-i) +: IN_W];
        x   = e;
        acc = acc + x * cw(i, k);
      end
      acc = acc >>> 9;
      res[OUT_W*(7-k) +: OUT_W] = acc[OUT_W-1:0];
    end
    return res;
  endfunction

  assign core_out = core_fn(core_in);

  // ---------------- reference model ----------------
  function automatic logic [8*IN_W-1:0] row_vec(input int r);
    logic [8*IN_W-1:0] v;
    int tmp;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      tmp = blk[r][i];
      v[IN_W*(7-i) +: IN_W] = tmp[IN_W-1:0];
    end
    return v;
  endfunction

  // 2D IDCT as matrix math: transform every row, then every column of the
  // intermediate matrix (widened by sign extension).
  task automatic ref_model();
    logic [8*OUT_W-1:0]      t [8];
    logic [8*IN_W-1:0]       v;
    logic signed [OUT_W-1:0] e;
    int                      x;
    for (int r = 0; r < 8; r++) t[r] = core_fn(row_vec(r));
    for (int c = 0; c < 8; c++) begin
      v = '0;
      for (int r = 0; r < 8; r++) begin
        e = t[r][OUT_W*(7-c) +: OUT_W];
        x = e;
        v[IN_W*(7-r) +: IN_W] = x[IN_W-1:0];
      end
      exp_col[c] = core_fn(v);
    end
  endtask

  task automatic fill_const(input int val);
    logic [OUT_W-1:0] e;
    e = val[OUT_W-1:0];
    for (int c = 0; c < 8; c++) exp_col[c] = {8{e}};
  endtask

  task automatic set_dc(input int val);
    for (int r = 0; r < 8; r++)
      for (int i = 0; i < 8; i++) blk[r][i] = 0;
    blk[0][0] = val;
  endtask

  task automatic set_rand();
    for (int r = 0; r < 8; r++)
      for (int i = 0; i < 8; i++) blk[r][i] = int'($urandom_range(0, 400)) - 200;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive rows 0..nrows-1 of blk; optional idle cycle before each row.
  task automatic send_rows(input int nrows, input bit gaps);
    int t;
    for (int r = 0; r < nrows; r++) begin
      if (gaps) begin
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom};
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = row_vec(r);
      t = 0;
      while (!in_ready && t < 40) begin
        @(posedge clk); #1;
        t++;
      end
      if (t == 40) chk("in_ready_timeout", 0, 1);
      #1;
      chk("core_in_row", core_in, in_data);
      chk("busy_row", busy, (r != 0));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Collect 8 columns; stall_col (0..7) holds out_ready low for stall_len
  // cycles; junk drives in_valid with garbage during the column pass.
  task automatic recv_block(input int stall_col, input int stall_len, input bit junk);
    for (int c = 0; c < 8; c++) begin
      in_valid = junk && (c < 7);
      in_data  = {$urandom, $urandom, $urandom};
      if (c == stall_col) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          #1;
          chk($sformatf("stall_idx_c%0d", c), out_idx, c);
          chk($sformatf("stall_data_c%0d", c), out_data, exp_col[c]);
          chk("stall_in_ready", in_ready, 0);
          chk("stall_out_valid", out_valid, 1);
          @(posedge clk); #1;
        end
      end
      out_ready = 1'b1;
      #1;
      chk($sformatf("out_valid_c%0d", c), out_valid, 1);
      chk($sformatf("out_idx_c%0d", c), out_idx, c);
      chk($sformatf("out_last_c%0d", c), out_last, (c == 7));
      chk($sformatf("out_data_c%0d", c), out_data, exp_col[c]);
      chk("in_ready_col", in_ready, 0);
      chk("busy_col", busy, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("in_ready_after", in_ready, 1);
    chk("out_valid_after", out_valid, 0);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;

    // Zero block
    set_dc(0);   fill_const(0);  send_rows(8, 1'b0); recv_block(8, 0, 1'b0);
    // DC positive / negative
    set_dc(64);  fill_const(7);  send_rows(8, 1'b0); recv_block(8, 0, 1'b0);
    set_dc(-64); fill_const(-9); send_rows(8, 1'b0); recv_block(8, 0, 1'b0);

    // Backpressure and gaps, then the same block without stalls
    set_rand(); ref_model();
    send_rows(8, 1'b1); recv_block(3, 5, 1'b0);
    send_rows(8, 1'b0); recv_block(8, 0, 1'b0);

    // Reset mid-block
    set_dc(64); send_rows(4, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    fill_const(7); send_rows(8, 1'b0); recv_block(8, 0, 1'b0);

    // Back-to-back blocks with input pushed during the column pass
    set_dc(64);  fill_const(7);  send_rows(8, 1'b0); recv_block(8, 0, 1'b1);
    set_dc(-64); fill_const(-9); send_rows(8, 1'b0); recv_block(8, 0, 1'b1);

    // Random blocks
    for (int b = 0; b < 8; b++) begin
      set_rand(); ref_model();
      send_rows(8, 1'($urandom_range(0, 1)));
      recv_block(int'($urandom_range(0, 8)), int'($urandom_range(1, 4)),
                 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
